can_tx_scheduler: RTL and testbench

Transmit-side scheduler for the CAN controller. It holds N_MB transmit mailbox requests and waits for bus idle. It then picks the highest-priority pending mailbox (lowest 11-bit base ID) and hands its fields to the frame encoder through a start/done handshake. It also handles arbitration loss, error retries and the per-mailbox retry limit. It sits between the host-side mailbox registers and the bit-level encoder, on the same sample_point bit-time strobe as can_decoder.

---
 rtl/can_tx_scheduler.sv | 146 ++++++++++++++
 tb/tb_can_tx_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: waits for bus idle, picks the lowest-ID pending mailbox,
// drives the frame encoder handshake and tracks per-mailbox retries and completion.
module can_tx_scheduler #(
  parameter int N_MB      = 4,
  parameter int IDLE_BITS = 11,
  parameter int MAX_RETRY = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_point,
  input  logic                 rx_bit,
  input  logic [N_MB-1:0]      tx_req,
  input  logic [N_MB*11-1:0]   tx_id,
  input  logic [N_MB*4-1:0]    tx_dlc,
  input  logic [N_MB*64-1:0]   tx_data,
  input  logic                 enc_busy,
  input  logic                 enc_done,
  input  logic                 enc_arb_lost,
  input  logic                 enc_error,
  output logic                 enc_start,
  output logic [10:0]          enc_id,
  output logic [3:0]           enc_dlc,
  output logic [63:0]          enc_data,
  output logic [N_MB-1:0]      tx_ack,
  output logic [N_MB-1:0]      tx_fail,
  output logic                 busy,
  output logic [2:0]           cur_mb
);

  localparam int CW = $clog2(IDLE_BITS + 1);

  // WAIT_IDLE: await bus idle | SELECT: pick and latch | START: wait for free encoder | WAIT_DONE: await outcome
  typedef enum logic [1:0] {WAIT_IDLE, SELECT, START, WAIT_DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   idle_cnt;
  logic [3:0]      retry [N_MB];
  logic [N_MB-1:0] hold, eligible;
  logic [N_MB-1:0] ack_hit, fail_hit, inc_hit;
  logic            fin;
  logic            sel_found;
  logic [2:0]      sel_idx;
  logic [10:0]     sel_id;
  logic [3:0]      sel_dlc;
  logic [63:0]     sel_data;

  assign eligible = tx_req & ~hold;
  assign busy     = (state == WAIT_DONE);

  // Strict less-than keeps the lowest index on equal IDs.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '1;
    sel_dlc   = '0;
    sel_data  = '0;
    for (int i = 0; i < N_MB; i++) begin
      if (eligible[i] && (!sel_found || tx_id[11*i +: 11] < sel_id)) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_id    = tx_id[11*i +: 11];
        sel_dlc   = tx_dlc[4*i +: 4];
        sel_data  = tx_data[64*i +: 64];
      end
    end
  end

  always_comb begin
    state_next = state;
    enc_start  = 1'b0;
    fin        = 1'b0;
    case (state)
      WAIT_IDLE: if (idle_cnt == CW'(IDLE_BITS) && |eligible) state_next = SELECT;
      SELECT:    state_next = sel_found ? START : WAIT_IDLE;
      START: begin
        if (!enc_busy) begin
          enc_start  = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (enc_error || enc_arb_lost || enc_done) begin
          fin        = 1'b1;
          state_next = WAIT_IDLE;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  // Outcome decode: error outranks arbitration loss, which outranks done.
  always_comb begin
    ack_hit  = '0;
    fail_hit = '0;
    inc_hit  = '0;
    for (int i = 0; i < N_MB; i++) begin
      if (fin && cur_mb == 3'(i)) begin
        if (enc_error) begin
          if (retry[i] == 4'(MAX_RETRY - 1)) fail_hit[i] = 1'b1;
          else                               inc_hit[i]  = 1'b1;
        end else if (!enc_arb_lost) begin
          ack_hit[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= WAIT_IDLE;
      idle_cnt <= '0;
      hold     <= '0;
      tx_ack   <= '0;
      tx_fail  <= '0;
      enc_id   <= '0;
      enc_dlc  <= '0;
      enc_data <= '0;
      cur_mb   <= '0;
      for (int i = 0; i < N_MB; i++) retry[i] <= '0;
    end else begin
      state   <= state_next;
      tx_ack  <= ack_hit;
      tx_fail <= fail_hit;
      hold    <= (hold | ack_hit | fail_hit) & tx_req;

      if (fin)
        idle_cnt <= '0;
      else if (sample_point)
        idle_cnt <= !rx_bit ? '0 :
                    (idle_cnt == CW'(IDLE_BITS)) ? idle_cnt : idle_cnt + CW'(1);

      if (state == SELECT && sel_found) begin
        enc_id   <= sel_id;
        enc_dlc  <= sel_dlc;
        enc_data <= sel_data;
        cur_mb   <= sel_idx;
      end

      for (int i = 0; i < N_MB; i++) begin
        if (ack_hit[i] || fail_hit[i]) retry[i] <= '0;
        else if (inc_hit[i])           retry[i] <= retry[i] + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a transaction-level model of the scheduler.
module tb_can_tx_scheduler;
  localparam int N  = 4;
  localparam int IB = 11;
  localparam int MR = 3;

  logic          clock;
  logic          reset;
  logic          sample_point;
  logic          rx_bit;
  logic [N-1:0]  tx_req;
  logic [N*11-1:0] tx_id;
  logic [N*4-1:0]  tx_dlc;
  logic [N*64-1:0] tx_data;
  logic          enc_busy, enc_done, enc_arb_lost, enc_error;
  logic          enc_start;
  logic [10:0]   enc_id;
  logic [3:0]    enc_dlc;
  logic [63:0]   enc_data;
  logic [N-1:0]  tx_ack, tx_fail;
  logic          busy;
  logic [2:0]    cur_mb;

  can_tx_scheduler #(.N_MB(N), .IDLE_BITS(IB), .MAX_RETRY(MR)) dut (
    .clock(clock), .reset(reset), .sample_point(sample_point), .rx_bit(rx_bit),
    .tx_req(tx_req), .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .enc_busy(enc_busy), .enc_done(enc_done), .enc_arb_lost(enc_arb_lost),
    .enc_error(enc_error), .enc_start(enc_start), .enc_id(enc_id), .enc_dlc(enc_dlc),
    .enc_data(enc_data), .tx_ack(tx_ack), .tx_fail(tx_fail), .busy(busy), .cur_mb(cur_mb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: where the transaction is in its life (pick pending, launch pending, in flight).
  int          m_idle;
  bit          m_pick, m_launch, m_fly;
  int          m_cur;
  logic [10:0] m_id;
  logic [3:0]  m_dlc;
  logic [63:0] m_data;
  int          m_retry [N];
  bit          m_hold [N];
  logic [N-1:0] m_ack, m_fail;

  int n_checks, n_pass;
  int cyc, sp_cnt, sp_total, rec_sp, sp11_cyc, dom_at, ack_cnt, start_sp;
  bit saw_start;
  int start_mb[$];
  int start_cyc[$];
  int rj, ro;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic void model_reset();
    m_idle = 0; m_pick = 0; m_launch = 0; m_fly = 0; m_cur = 0;
    m_id = '0; m_dlc = '0; m_data = '0; m_ack = '0; m_fail = '0;
    for (int i = 0; i < N; i++) begin m_retry[i] = 0; m_hold[i] = 0; end
  endfunction

  function automatic void model_step();
    bit any_el, clr, found;
    logic [N-1:0] nack, nfail;
    int best;
    if (reset) begin model_reset(); return; end
    any_el = 0; clr = 0; found = 0; best = 0; nack = '0; nfail = '0;
    for (int i = 0; i < N; i++) if (tx_req[i] && !m_hold[i]) any_el = 1;
    if (m_pick) begin
      m_pick = 0;
      for (int i = 0; i < N; i++)
        if (tx_req[i] && !m_hold[i])
          if (!found || tx_id[11*i +: 11] < tx_id[11*best +: 11]) begin found = 1; best = i; end
      if (found) begin
        m_launch = 1; m_cur = best;
        m_id = tx_id[11*best +: 11]; m_dlc = tx_dlc[4*best +: 4]; m_data = tx_data[64*best +: 64];
      end
    end else if (m_launch) begin
      if (!enc_busy) begin m_launch = 0; m_fly = 1; end
    end else if (m_fly) begin
      if (enc_error) begin
        m_retry[m_cur]++;
        if (m_retry[m_cur] == MR) begin nfail[m_cur] = 1'b1; m_retry[m_cur] = 0; end
      end else if (!enc_arb_lost && enc_done) begin
        nack[m_cur] = 1'b1; m_retry[m_cur] = 0;
      end
      if (enc_error || enc_arb_lost || enc_done) begin m_fly = 0; clr = 1; end
    end else if (m_idle == IB && any_el) begin
      m_pick = 1;
    end
    for (int i = 0; i < N; i++) m_hold[i] = (m_hold[i] || nack[i] || nfail[i]) && tx_req[i];
    if (clr) m_idle = 0;
    else if (sample_point) m_idle = rx_bit ? ((m_idle < IB) ? m_idle + 1 : IB) : 0;
    m_ack = nack; m_fail = nfail;
  endfunction

  // One clock: inputs already set after the falling edge; compare, advance model, move on.
  task automatic tick();
    #1;
    chk("enc_start", 64'(enc_start), 64'(m_launch && !enc_busy));
    chk("busy",      64'(busy),      64'(m_fly));
    chk("tx_ack",    64'(tx_ack),    64'(m_ack));
    chk("tx_fail",   64'(tx_fail),   64'(m_fail));
    chk("cur_mb",    64'(cur_mb),    64'(m_cur));
    chk("enc_id",    64'(enc_id),    64'(m_id));
    chk("enc_dlc",   64'(enc_dlc),   64'(m_dlc));
    chk("enc_data",  enc_data,       m_data);
    ack_cnt += $countones(tx_ack);
    if (enc_start) begin
      saw_start = 1; start_mb.push_back(int'(cur_mb)); start_cyc.push_back(cyc); start_sp = sp_total;
    end
    if (reset) begin
      sp_total = 0; rec_sp = 0;
    end else if (sample_point) begin
      sp_total++;
      if (rx_bit) begin rec_sp++; if (rec_sp == IB) sp11_cyc = cyc; end
      else rec_sp = 0;
    end
    model_step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sample_point = (sp_cnt == 0);
      rx_bit = !(sample_point && (sp_total + 1 == dom_at));
      sp_cnt = (sp_cnt + 1) % 4;
      tick();
    end
  endtask

  task automatic set_mb(input int i, input logic [10:0] id, input logic [3:0] d, input logic [63:0] dat);
    tx_id[11*i +: 11] = id; tx_dlc[4*i +: 4] = d; tx_data[64*i +: 64] = dat;
  endtask

  task automatic do_reset();
    reset = 1; enc_done = 0; enc_arb_lost = 0; enc_error = 0; enc_busy = 0;
    dom_at = -1; sp_cnt = 1;
    run(2);
    reset = 0; sp_cnt = 0;
    start_mb.delete(); start_cyc.delete();
    chk("reset_outputs", 64'({enc_start, busy, tx_ack, tx_fail, cur_mb, enc_id, enc_dlc}), 64'd0);
    chk("reset_data", enc_data, 64'd0);
  endtask

  task automatic wait_start(input string nm);
    saw_start = 0;
    for (int i = 0; i < 300 && !saw_start; i++) run(1);
    chk(nm, 64'(saw_start), 64'd1);
  endtask

  task automatic pulse(input bit d, input bit a, input bit e);
    enc_done = d; enc_arb_lost = a; enc_error = e;
    run(1);
    enc_done = 0; enc_arb_lost = 0; enc_error = 0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; ack_cnt = 0; sp11_cyc = 0; start_sp = 0;
    reset = 1; sample_point = 0; rx_bit = 1; tx_req = '0; tx_id = '0; tx_dlc = '0; tx_data = '0;
    enc_busy = 0; enc_done = 0; enc_arb_lost = 0; enc_error = 0;
    sp_cnt = 0; sp_total = 0; rec_sp = 0; dom_at = -1;
    repeat (3) @(negedge clock);
    model_reset();

    // Single mailbox, ID/DLC/data latched, exact start latency, ack, no restart.
    set_mb(2, 11'h123, 4'd2, 64'hBEEF);
    tx_req = 4'b0100;
    do_reset();
    wait_start("t1_start");
    chk("t1_start_latency", 64'(start_cyc[0] - sp11_cyc), 64'd3);
    chk("t1_start_sp", 64'(start_sp), 64'd11);
    chk("t1_enc_id", 64'(enc_id), 64'h123);
    chk("t1_enc_dlc", 64'(enc_dlc), 64'd2);
    chk("t1_enc_data", enc_data, 64'hBEEF);
    run(1);
    pulse(1, 0, 0);
    chk("t1_ack", 64'(tx_ack), 64'b0100);
    saw_start = 0;
    run(80);
    chk("t1_no_restart", 64'(saw_start), 64'd0);

    // Priority with a tie: order mb1, mb3, mb0.
    tx_req = 4'b0000;
    set_mb(0, 11'h200, 4'd1, 64'h10); set_mb(1, 11'h100, 4'd3, 64'h11);
    set_mb(2, 11'h050, 4'd4, 64'h12); set_mb(3, 11'h100, 4'd5, 64'h13);
    tx_req = 4'b1011;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_start("t2_start");
      run(1);
      pulse(1, 0, 0);
    end
    chk("t2_count", 64'(start_mb.size()), 64'd3);
    chk("t2_first", 64'(start_mb[0]), 64'd1);
    chk("t2_second", 64'(start_mb[1]), 64'd3);
    chk("t2_third", 64'(start_mb[2]), 64'd0);

    // Dominant bit on the 6th idle sample point restarts the idle count.
    tx_req = 4'b0001;
    do_reset();
    dom_at = 6;
    wait_start("t3_start");
    chk("t3_start_sp", 64'(start_sp), 64'd17);
    chk("t3_start_latency", 64'(start_cyc[0] - sp11_cyc), 64'd3);
    dom_at = -1;
    run(1);
    pulse(1, 0, 0);

    // Arbitration loss then success: two starts on mb0, one ack.
    do_reset();
    ack_cnt = 0;
    wait_start("t4_start1");
    run(1);
    pulse(0, 1, 0);
    wait_start("t4_start2");
    run(1);
    pulse(1, 0, 0);
    chk("t4_ack", 64'(tx_ack), 64'b0001);
    run(60);
    chk("t4_starts", 64'(start_mb.size()), 64'd2);
    chk("t4_same_mb", 64'(start_mb[1]), 64'd0);
    chk("t4_ack_count", 64'(ack_cnt), 64'd1);

    // Retry exhaustion at MR=3, then re-request.
    do_reset();
    for (int k = 0; k < MR; k++) begin
      wait_start("t5_start");
      run(1);
      pulse(0, 0, 1);
    end
    chk("t5_fail", 64'(tx_fail), 64'b0001);
    saw_start = 0;
    run(80);
    chk("t5_no_fourth", 64'(saw_start), 64'd0);
    tx_req = 4'b0000; run(1); tx_req = 4'b0001;
    wait_start("t5_reattempt");
    run(1);
    pulse(1, 0, 0);

    // Reset during flight with coincident done and error.
    do_reset();
    wait_start("t6_start");
    run(2);
    ack_cnt = 0;
    reset = 1; enc_done = 1; enc_error = 1;
    run(1);
    reset = 0; enc_done = 0; enc_error = 0; sp_cnt = 0;
    start_mb.delete();
    chk("t6_outputs", 64'({enc_start, busy, tx_ack, tx_fail, cur_mb, enc_id, enc_dlc}), 64'd0);
    chk("t6_data", enc_data, 64'd0);
    wait_start("t6_restart");
    chk("t6_no_ack", 64'(ack_cnt), 64'd0);
    chk("t6_start_sp", 64'(start_sp), 64'd11);
    run(1);
    pulse(1, 0, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 29) == 0) begin rj = $urandom_range(0, N-1); tx_req[rj] = ~tx_req[rj]; end
      if ($urandom_range(0, 39) == 0) begin
        rj = $urandom_range(0, N-1);
        set_mb(rj, 11'($urandom_range(0, 3) * 300), 4'($urandom_range(0, 8)), {$urandom, $urandom});
      end
      sample_point = ($urandom_range(0, 2) == 0);
      rx_bit = ($urandom_range(0, 24) != 0);
      enc_busy = ($urandom_range(0, 3) == 0);
      enc_done = 0; enc_arb_lost = 0; enc_error = 0;
      if (m_fly && $urandom_range(0, 5) == 0) begin
        ro = $urandom_range(1, 7);
        enc_done = ro[0]; enc_arb_lost = ro[1]; enc_error = ro[2];
      end else if ($urandom_range(0, 59) == 0) begin
        enc_done = 1;
      end
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 0; enc_done = 0; enc_arb_lost = 0; enc_error = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
